// File: rtl/pattern_scan_scheduler.sv
// Purpose : round-robin scheduler sharing one serial 2-flag pattern detector between NUM_REQ requesters.
// Latency : req sampled in IDLE (cycle 0), grant/det_clr at 1, bits at 2..WORD_W+1, done at WORD_W+3.
// Backpressure: none; req is a level request, and changes to req/word_in during a scan are ignored.
// Optional build macro: SCAN_EARLY_STOP_EN ends SHIFT as soon as det_flags reads 2'b11.
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   req, word_in          per-requester level request and parallel word (slice k at k*WORD_W)
//   grant                 one-hot pulse in the cycle the winner's word is captured
//   busy                  high whenever the scheduler is not idle
//   det_clr/bit/valid     detector clear pulse, serial bit (MSB first) and bit qualifier
//   det_flags             detector sticky flags (registered inside the detector)
//   done, result, done_id completion pulse, captured flags and owning requester index
module pattern_scan_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int WORD_W  = 10,
  parameter int ID_W    = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*WORD_W-1:0] word_in,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      det_clr,
  output logic                      det_bit,
  output logic                      det_valid,
  input  logic [1:0]                det_flags,
  output logic                      done,
  output logic [1:0]                result,
  output logic [ID_W-1:0]           done_id
);

  localparam int CNT_W = $clog2(WORD_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state, nxt;
  logic [CNT_W-1:0]    cnt;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     win_id;
  logic [WORD_W-1:0]   shreg;

  // Round-robin pick: rotate req so the pointer position lands on bit 0,
  // take the lowest set bit, then rotate the offset back into an index.
  logic [2*NUM_REQ-1:0] req_rot;
  logic                 pick_vld;
  logic [ID_W-1:0]      pick;
  int                   pick_sum;

  always_comb begin
    req_rot  = {req, req} >> ptr;
    pick_vld = 1'b0;
    pick     = '0;
    pick_sum = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && req_rot[i]) begin
        pick_vld = 1'b1;
        pick_sum = int'(ptr) + i;
        if (pick_sum >= NUM_REQ) pick_sum = pick_sum - NUM_REQ;
        pick     = ID_W'(pick_sum);
      end
    end
  end

  // Early termination only ever looks at the detector's registered flags,
  // so the bit on the wire in the stopping cycle is still consumed.
  logic early_stop;
`ifdef SCAN_EARLY_STOP_EN
  assign early_stop = (det_flags == 2'b11);
`else
  assign early_stop = 1'b0;
`endif

  always_comb begin
    nxt       = state;
    grant     = '0;
    busy      = 1'b1;
    det_clr   = 1'b0;
    det_bit   = 1'b0;
    det_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (pick_vld) nxt = LOAD;
      end
      LOAD: begin
        grant   = NUM_REQ'(1) << win_id;
        det_clr = 1'b1;
        nxt     = SHIFT;
      end
      SHIFT: begin
        det_valid = 1'b1;
        det_bit   = shreg[WORD_W-1];
        if (cnt == CNT_W'(WORD_W-1) || early_stop) nxt = WAIT;
      end
      WAIT: nxt = DONE;
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      win_id  <= '0;
      shreg   <= '0;
      result  <= '0;
      done_id <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (pick_vld) win_id <= pick;
        LOAD: begin
          shreg <= word_in[int'(win_id)*WORD_W +: WORD_W];
          ptr   <= (int'(win_id) == NUM_REQ-1) ? '0 : win_id + 1'b1;
        end
        // Shifting left keeps the next bit to send in the MSB position.
        SHIFT: shreg <= shreg << 1;
        WAIT: begin
          result  <= det_flags;
          done_id <= win_id;
        end
        default: ;
      endcase
      cnt <= (state == SHIFT && nxt == SHIFT) ? cnt + 1'b1 : '0;
    end
  end

endmodule
